seq_mult_n: RTL

- Sequential shift-and-add unsigned multiplier: N×N operands in, 2N-bit product out.
- Sits directly upstream of the adder datapath: each cycle it stages operands into a 2N-bit ripple-carry adder, then registers the adder's sum back into its accumulator.
- Serves as the area-cheap, multi-cycle alternative to the array multiplier.
- Valid/ready handshakes on both input and output.

---
 rtl/seq_mult_n_pkg.sv | 19 +
 rtl/seq_mult_n_rca.sv | 29 ++
 rtl/seq_mult_n.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seq_mult_n_pkg.sv
// seq_mult_n_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - state_t   : FSM state encoding (IDLE, RUN, DONE)
//   - cnt_width : width of the step counter for a given operand width
package seq_mult_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra bit over clog2 so the counter can represent N-1 for any N
  // without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_n_rca.sv
// rca_n
// Plain n-bit ripple-carry adder used as the accumulate adder of seq_mult_n.
// Ports:
//   a, b : n-bit addends
//   ci   : carry in
//   s    : n-bit sum
//   co   : carry out
module rca_n #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         ci,
  output logic [n-1:0] s,
  output logic         co
);

  logic [n:0] w_c;

  assign w_c[0] = ci;

  for (genvar gi = 0; gi < n; gi++) begin : g_bit
    assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi+1] = (a[gi] & b[gi]) | (a[gi] & w_c[gi]) | (b[gi] & w_c[gi]);
  end

  assign co = w_c[n];

endmodule

// File: rtl/seq_mult_n.sv
// seq_mult_n
// Sequential shift-and-add unsigned multiplier, N x N -> 2N.
// One partial product is accumulated per RUN cycle through a 2N-bit
// ripple-carry adder (rca_n); the result is presented in DONE until taken.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   in_valid  : a/b valid
//   in_ready  : operands accepted (high only in IDLE, low during reset)
//   a, b      : N-bit unsigned multiplicand / multiplier
//   out_valid : p holds a completed product
//   out_ready : downstream accepts p
//   p         : 2N-bit product (0 whenever out_valid is low)
//
// Build option:
//   SEQ_MULT_EARLY_TERM_EN : finish RUN as soon as the remaining multiplier
//                            bits are all zero. Product is unchanged.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one shift-and-add step per cycle
// DONE  | product valid, waiting for out_ready
module seq_mult_n
  import seq_mult_n_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);

  localparam int CW = cnt_width(N);

  state_t         r_state;
  state_t         w_next;
  logic [2*N-1:0] r_mcand;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;

  logic [2*N-1:0] w_addend;
  logic [2*N-1:0] w_sum;
  logic           w_co_unused;
  logic           w_accept;
  logic           w_last;

  // Gating the addend instead of muxing the sum keeps the adder in the path
  // every cycle; adding zero leaves acc unchanged.
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  rca_n #(.n(2*N)) u_rca (
    .a  (r_acc),
    .b  (w_addend),
    .ci (1'b0),
    .s  (w_sum),
    .co (w_co_unused)
  );

  assign w_accept = in_valid && in_ready;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign w_last = (r_cnt == CW'(N-1)) || ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_cnt == CW'(N-1));
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (r_state == ST_IDLE) && !rst;
    out_valid = (r_state == ST_DONE);
    p         = '0;
    if (r_state == ST_DONE) p = r_acc;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mcand  <= {{N{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
